regfile_2w: RTL and testbench

- Parametrised two-write / two-read register file.
- Successor to the single-write regfile, used as the datapath register store.
- Adds a second write port, optional write-through bypass, optional hardwired-zero register 0, and a multi-cycle background clear sequencer.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_rdmux.sv | 48 ++++
 rtl/regfile_2w.sv | 135 +++++++++++++
 tb/tb_regfile_2w.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared definitions for the two-write / two-read register file:
//   - clear-sequencer state encoding
//   - default data width and address width
package regfile_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam int N_DEF = 16;
  localparam int K_DEF = 4;

endpackage

// File: rtl/regfile_rdmux.sv
// regfile_rdmux
// Combinational read-port selector for regfile_2w. Chooses between the stored
// word and the in-flight write data, and forces register 0 to zero when it is
// hardwired.
// Ports:
//   ra      in   K  read address
//   mem_rd  in   N  stored word at ra
//   byp_en  in   1  bypass allowed this cycle (file is idle)
//   we0/wa0/wd0  in  write port 0 enable/address/data
//   we1/wa1/wd1  in  write port 1 enable/address/data (higher priority)
//   rd      out  N  selected read data
module regfile_rdmux
  import regfile_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int K       = K_DEF,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic [K-1:0] ra,
  input  logic [N-1:0] mem_rd,
  input  logic         byp_en,
  input  logic         we0,
  input  logic [K-1:0] wa0,
  input  logic [N-1:0] wd0,
  input  logic         we1,
  input  logic [K-1:0] wa1,
  input  logic [N-1:0] wd1,
  output logic [N-1:0] rd
);

  always_comb begin
    rd = mem_rd;
    if ((BYPASS != 0) && byp_en) begin
      // Port 1 wins a same-address collision, so it must win the bypass too.
      if (we1 && (ra == wa1)) begin
        rd = wd1;
      end else if (we0 && (ra == wa0)) begin
        rd = wd0;
      end
    end
    // The hardwired zero overrides bypass as well as storage.
    if ((ZERO_R0 != 0) && (ra == '0)) begin
      rd = '0;
    end
  end

endmodule

// File: rtl/regfile_2w.sv
// regfile_2w
// Two-write / two-read register file with optional write-through bypass,
// optional hardwired-zero register 0 and a background clear sequencer that
// zeroes one register per cycle.
// Ports:
//   clk      in   1  rising-edge clock
//   rst_n    in   1  synchronous active-low reset
//   we0/wa0/wd0  in  write port 0 enable/address/data
//   we1/wa1/wd1  in  write port 1 enable/address/data (wins collisions)
//   ra0/ra1  in   K  read addresses
//   rd0/rd1  out  N  combinational read data
//   clr      in   1  request to zero the whole file
//   busy     out  1  clear sequence in progress
//
// state | meaning
// IDLE  | normal reads/writes, bypass active, accepts clr
// CLEAR | zeroing mem[cnt] each cycle; writes, clr and bypass ignored
module regfile_2w
  import regfile_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int K       = K_DEF,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we0,
  input  logic [K-1:0] wa0,
  input  logic [N-1:0] wd0,
  input  logic         we1,
  input  logic [K-1:0] wa1,
  input  logic [N-1:0] wd1,
  input  logic [K-1:0] ra0,
  input  logic [K-1:0] ra1,
  output logic [N-1:0] rd0,
  output logic [N-1:0] rd1,
  input  logic         clr,
  output logic         busy
);

  localparam int DEPTH = 1 << K;

  logic [N-1:0] mem_q [DEPTH];
  logic [N-1:0] mem_d [DEPTH];
  state_e       state_q, state_d;
  logic [K-1:0] cnt_q, cnt_d;
  logic         busy_q, busy_d;

  logic         wr0_ok, wr1_ok;

  // With a hardwired register 0 its storage simply never leaves reset value.
  assign wr0_ok = we0 && ((ZERO_R0 == 0) || (wa0 != '0));
  assign wr1_ok = we1 && ((ZERO_R0 == 0) || (wa1 != '0));

  always_comb begin
    mem_d   = mem_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        // Port 1 is applied last so it overwrites port 0 on a collision.
        if (wr0_ok) mem_d[wa0] = wd0;
        if (wr1_ok) mem_d[wa1] = wd1;
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      CLEAR: begin
        mem_d[cnt_q] = '0;
        cnt_d        = cnt_q + 1'b1;
        if (cnt_q == {K{1'b1}}) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;

  regfile_rdmux #(
    .N(N), .K(K), .BYPASS(BYPASS), .ZERO_R0(ZERO_R0)
  ) u_rdmux0 (
    .ra     (ra0),
    .mem_rd (mem_q[ra0]),
    .byp_en (state_q == IDLE),
    .we0    (we0),
    .wa0    (wa0),
    .wd0    (wd0),
    .we1    (we1),
    .wa1    (wa1),
    .wd1    (wd1),
    .rd     (rd0)
  );

  regfile_rdmux #(
    .N(N), .K(K), .BYPASS(BYPASS), .ZERO_R0(ZERO_R0)
  ) u_rdmux1 (
    .ra     (ra1),
    .mem_rd (mem_q[ra1]),
    .byp_en (state_q == IDLE),
    .we0    (we0),
    .wa0    (wa0),
    .wd0    (wd0),
    .we1    (we1),
    .wa1    (wa1),
    .wd1    (wd1),
    .rd     (rd1)
  );

endmodule

// File: tb/tb_regfile_2w.sv
module tb_regfile_2w;

  logic        clk;
  logic        rst_n;
  logic        we0, we1, clr;
  logic [3:0]  wa0, wa1, ra0, ra1;
  logic [15:0] wd0, wd1;
  logic [15:0] rd0_a, rd1_a, rd0_b, rd1_b;
  logic        busy_a, busy_b;

  int checks = 0;
  int errors = 0;

  // dut_a: BYPASS=1, ZERO_R0=0.  dut_b: BYPASS=0, ZERO_R0=1.  Shared stimulus.
  regfile_2w #(.N(16), .K(4), .BYPASS(1), .ZERO_R0(0)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra0(ra0), .ra1(ra1), .rd0(rd0_a), .rd1(rd1_a),
    .clr(clr), .busy(busy_a)
  );

  regfile_2w #(.N(16), .K(4), .BYPASS(0), .ZERO_R0(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra0(ra0), .ra1(ra1), .rd0(rd0_b), .rd1(rd1_b),
    .clr(clr), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%04h exp=0x%04h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    we0 = 1'b0; we1 = 1'b0; clr = 1'b0;
    wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
  endtask

  initial begin
    idle_in();
    ra0 = '0; ra1 = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    // reset state
    ra0 = 4'd5; ra1 = 4'd15; #1;
    chk("rst_rd0", rd0_a, 16'h0);
    chk("rst_rd1", rd1_a, 16'h0);
    chk("rst_busy", {15'b0, busy_a}, 16'h0);
    chk("rst_busy_b", {15'b0, busy_b}, 16'h0);

    // dual write, different addresses
    we0 = 1; wa0 = 4'd2; wd0 = 16'd10;
    we1 = 1; wa1 = 4'd3; wd1 = 16'd15;
    tick(); idle_in();
    ra0 = 4'd2; ra1 = 4'd3; #1;
    chk("dual_rd0", rd0_a, 16'd10);
    chk("dual_rd1", rd1_a, 16'd15);
    chk("dual_rd0_b", rd0_b, 16'd10);
    chk("dual_rd1_b", rd1_b, 16'd15);

    // collision: port 1 wins
    we0 = 1; wa0 = 4'd7; wd0 = 16'h1111;
    we1 = 1; wa1 = 4'd7; wd1 = 16'h2222;
    tick(); idle_in();
    ra0 = 4'd7; #1;
    chk("coll_rd0", rd0_a, 16'h2222);
    chk("coll_rd0_b", rd0_b, 16'h2222);

    // bypass vs no bypass, same cycle as the write
    we0 = 1; wa0 = 4'd4; wd0 = 16'd42;
    we1 = 1; wa1 = 4'd5; wd1 = 16'd77;
    ra0 = 4'd4; ra1 = 4'd5; #1;
    chk("byp_rd0", rd0_a, 16'd42);
    chk("byp_rd1", rd1_a, 16'd77);
    chk("nobyp_rd0", rd0_b, 16'd0);
    chk("nobyp_rd1", rd1_b, 16'd0);
    tick(); idle_in(); #1;
    chk("nobyp_after_rd0", rd0_b, 16'd42);
    chk("nobyp_after_rd1", rd1_b, 16'd77);

    // bypass priority: port 1 over port 0, nothing committed
    we0 = 1; wa0 = 4'd6; wd0 = 16'd1;
    we1 = 1; wa1 = 4'd6; wd1 = 16'd2;
    ra0 = 4'd6; #1;
    chk("byp_prio", rd0_a, 16'd2);
    idle_in();
    tick();
    chk("byp_no_commit", rd0_a, 16'd0);

    // register 0: normal in dut_a, hardwired zero in dut_b
    we0 = 1; wa0 = 4'd0; wd0 = 16'hABCD;
    ra0 = 4'd0; #1;
    chk("r0_byp_a", rd0_a, 16'hABCD);
    chk("r0_byp_b", rd0_b, 16'h0);
    tick(); idle_in(); #1;
    chk("r0_stored_a", rd0_a, 16'hABCD);
    chk("r0_stored_b", rd0_b, 16'h0);

    // clear sequence
    we1 = 1; wa1 = 4'd9; wd1 = 16'd99;
    tick(); idle_in();
    // write in the clr cycle commits, then gets cleared
    clr = 1; we0 = 1; wa0 = 4'd11; wd0 = 16'd123;
    tick(); idle_in();
    chk("clr_busy_k0", {15'b0, busy_a}, 16'h1);
    for (int k = 1; k < 16; k++) begin
      if (k == 3) begin
        // register 9 not yet cleared; writes dropped and not bypassed
        we1 = 1; wa1 = 4'd9; wd1 = 16'd5;
        we0 = 1; wa0 = 4'd1; wd0 = 16'd5;
        ra0 = 4'd9; ra1 = 4'd11; #1;
        chk("clr_mix_rd0", rd0_a, 16'd99);
        chk("clr_mix_rd1", rd1_a, 16'd123);
      end
      if (k == 8) clr = 1;
      tick(); idle_in();
      chk($sformatf("clr_busy_k%0d", k), {15'b0, busy_a}, 16'h1);
    end
    tick();
    chk("clr_busy_end", {15'b0, busy_a}, 16'h0);
    chk("clr_busy_end_b", {15'b0, busy_b}, 16'h0);
    ra0 = 4'd9; ra1 = 4'd1; #1;
    chk("clr_r9", rd0_a, 16'd0);
    chk("clr_r1", rd1_a, 16'd0);
    ra0 = 4'd11; ra1 = 4'd7; #1;
    chk("clr_r11", rd0_a, 16'd0);
    chk("clr_r7", rd1_a, 16'd0);

    // reset in the middle of a clear
    we0 = 1; wa0 = 4'd12; wd0 = 16'h0055;
    tick(); idle_in();
    clr = 1;
    tick(); idle_in();
    for (int k = 1; k < 5; k++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; #1;
    chk("rstclr_busy", {15'b0, busy_a}, 16'h0);
    for (int a = 0; a < 16; a++) begin
      ra0 = 4'(a); ra1 = 4'(a); #1;
      chk($sformatf("rstclr_r%0d", a), rd0_a, 16'h0);
      chk($sformatf("rstclr_b_r%0d", a), rd1_b, 16'h0);
    end
    we0 = 1; wa0 = 4'd3; wd0 = 16'h1234;
    tick(); idle_in();
    ra0 = 4'd3; #1;
    chk("post_rst_wr", rd0_a, 16'h1234);
    chk("post_rst_wr_b", rd0_b, 16'h1234);
    chk("post_rst_busy", {15'b0, busy_a}, 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
